sd_block_responder: RTL and testbench

- Host-side model of the MiSTer SD block protocol for simulation builds.
- Answers drive-side sector requests (sd_lba/sd_rd/sd_wr) from the disk track loader.
- Read requests stream 512 bytes from a backing image memory into the drive buffer. Write requests pull 512 bytes out of the drive buffer into the image.
- Also issues the img_mounted/img_size announcement when the bench requests a mount.

---
 rtl/sd_block_responder.sv | 175 +++++++++++++++++
 tb/tb_sd_block_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_responder.sv
// sd_block_responder
//   Host-side model of the MiSTer SD block protocol, used in simulation builds.
//   It answers sector requests from the drive's track loader. A read streams
//   512 bytes from a backing image memory into the drive buffer. A write pulls
//   512 bytes out of the drive buffer and stores them in the image. It also
//   announces a mount (img_mounted/img_size) when asked to.
//
//   Build option: define SD_RESP_WRPROT_EN to write-protect the image. Writes
//   then still run the full handshake, but mem_wr is never asserted and
//   img_readonly is tied high.
//
// Parameters
//   IMG_ADDR_W   byte-address width of the image (2^(IMG_ADDR_W-9) sectors)
//   ACK_DELAY    idle cycles between accepting a request and raising sd_ack (1..255)
//
// Ports
//   clk_sys, reset_n                  clock, asynchronous active-low reset
//   mount_req, mount_size             mount pulse and image size in bytes
//   img_mounted, img_size             one-cycle mount strobe, registered size
//   img_readonly                      write-protect flag
//   sd_lba, sd_rd, sd_wr              drive request (sector, read level, write level)
//   sd_ack                            high for the whole byte transfer
//   sd_buff_addr/dout/wr/din          drive buffer port (1-cycle read latency on din)
//   mem_addr/rd/q/wr/d                image memory port (1-cycle read latency on q)
//   busy                              FSM not idle
module sd_block_responder #(
   parameter int unsigned IMG_ADDR_W = 20,
   parameter int unsigned ACK_DELAY  = 4
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  mount_req,
   input  logic [63:0]           mount_size,
   output logic                  img_mounted,
   output logic [63:0]           img_size,
   output logic                  img_readonly,
   input  logic [31:0]           sd_lba,
   input  logic                  sd_rd,
   input  logic                  sd_wr,
   output logic                  sd_ack,
   output logic [8:0]            sd_buff_addr,
   output logic [7:0]            sd_buff_dout,
   output logic                  sd_buff_wr,
   input  logic [7:0]            sd_buff_din,
   output logic [IMG_ADDR_W-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [7:0]            mem_q,
   output logic                  mem_wr,
   output logic [7:0]            mem_d,
   output logic                  busy
);

   localparam int unsigned SEC_W = IMG_ADDR_W - 9;
   localparam logic [7:0] DELAY_LAST = 8'(ACK_DELAY - 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StDelay   = 3'd1;
   localparam logic [2:0] StRdFetch = 3'd2;
   localparam logic [2:0] StRdPush  = 3'd3;
   localparam logic [2:0] StWrAddr  = 3'd4;
   localparam logic [2:0] StWrCap   = 3'd5;
   localparam logic [2:0] StDone    = 3'd6;

`ifdef SD_RESP_WRPROT_EN
   localparam logic WRITE_EN = 1'b0;
`else
   localparam logic WRITE_EN = 1'b1;
`endif

   logic [2:0]       state_q, state_d;
   logic [8:0]       byte_q, byte_d;
   logic [7:0]       delay_q, delay_d;
   logic [SEC_W-1:0] lba_q, lba_d;
   logic             is_rd_q, is_rd_d;
   logic             in_range_q, in_range_d;
   logic [63:0]      img_size_q;
   logic             img_mounted_q;

   // Range decision is taken once at accept; later mounts do not affect it.
   logic [54:0] req_sector;
   logic        lba_fits;
   logic        req_in_range;

   always_comb begin
      req_sector   = {23'd0, sd_lba};
      lba_fits     = (({32'd0, sd_lba}) >> SEC_W) == 64'd0;
      req_in_range = (req_sector < img_size_q[63:9]) && lba_fits;
   end

   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      delay_d    = delay_q;
      lba_d      = lba_q;
      is_rd_d    = is_rd_q;
      in_range_d = in_range_q;
      case (state_q)
         StIdle: begin
            if (sd_rd || sd_wr) begin
               lba_d      = sd_lba[SEC_W-1:0];
               is_rd_d    = sd_rd;  // read wins when both are high
               in_range_d = req_in_range;
               delay_d    = 8'd0;
               state_d    = StDelay;
            end
         end
         StDelay: begin
            if (delay_q == DELAY_LAST) begin
               byte_d  = 9'd0;
               state_d = is_rd_q ? StRdFetch : StWrAddr;
            end else begin
               delay_d = delay_q + 8'd1;
            end
         end
         StRdFetch: state_d = StRdPush;
         StRdPush: begin
            // 511 + 1 wraps to 0 as we leave for DONE.
            byte_d  = byte_q + 9'd1;
            state_d = (byte_q == 9'd511) ? StDone : StRdFetch;
         end
         StWrAddr: state_d = StWrCap;
         StWrCap: begin
            byte_d  = byte_q + 9'd1;
            state_d = (byte_q == 9'd511) ? StDone : StWrAddr;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         byte_q        <= 9'd0;
         delay_q       <= 8'd0;
         lba_q         <= '0;
         is_rd_q       <= 1'b0;
         in_range_q    <= 1'b0;
         img_size_q    <= 64'd0;
         img_mounted_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         delay_q       <= delay_d;
         lba_q         <= lba_d;
         is_rd_q       <= is_rd_d;
         in_range_q    <= in_range_d;
         img_mounted_q <= mount_req;
         if (mount_req) begin
            img_size_q <= mount_size;
         end
      end
   end

   // Outputs decode the registered state, so they drop as soon as reset hits.
   logic xfer;

   always_comb begin
      xfer         = (state_q == StRdFetch) || (state_q == StRdPush) ||
                     (state_q == StWrAddr)  || (state_q == StWrCap);
      sd_ack       = xfer;
      sd_buff_addr = xfer ? byte_q : 9'd0;
      sd_buff_wr   = (state_q == StRdPush);
      sd_buff_dout = ((state_q == StRdPush) && in_range_q) ? mem_q : 8'h00;
      mem_addr     = xfer ? {lba_q, byte_q} : '0;
      mem_rd       = (state_q == StRdFetch) && in_range_q;
      mem_wr       = (state_q == StWrCap) && in_range_q && WRITE_EN;
      mem_d        = (state_q == StWrCap) ? sd_buff_din : 8'h00;
      busy         = (state_q != StIdle);
      img_mounted  = img_mounted_q;
      img_size     = img_size_q;
      img_readonly = ~WRITE_EN;
   end

endmodule

// File: tb/tb_sd_block_responder.sv
// Testbench for sd_block_responder: scoreboard of expected buffer pushes,
// reference image model and randomized sector transfers.
module tb_sd_block_responder;

   localparam int unsigned IMG_ADDR_W = 20;
   localparam int unsigned ACK_DELAY  = 4;
   localparam int          IMG_BYTES  = 1 << IMG_ADDR_W;
   localparam int          CAP_SECT   = 1 << (IMG_ADDR_W - 9);

`ifdef SD_RESP_WRPROT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic                  clk;
   logic                  reset_n;
   logic                  mount_req;
   logic [63:0]           mount_size;
   logic                  img_mounted;
   logic [63:0]           img_size;
   logic                  img_readonly;
   logic [31:0]           sd_lba;
   logic                  sd_rd;
   logic                  sd_wr;
   logic                  sd_ack;
   logic [8:0]            sd_buff_addr;
   logic [7:0]            sd_buff_dout;
   logic                  sd_buff_wr;
   logic [7:0]            sd_buff_din;
   logic [IMG_ADDR_W-1:0] mem_addr;
   logic                  mem_rd;
   logic [7:0]            mem_q;
   logic                  mem_wr;
   logic [7:0]            mem_d;
   logic                  busy;

   sd_block_responder #(
      .IMG_ADDR_W(IMG_ADDR_W),
      .ACK_DELAY (ACK_DELAY)
   ) dut (
      .clk_sys     (clk),
      .reset_n     (reset_n),
      .mount_req   (mount_req),
      .mount_size  (mount_size),
      .img_mounted (img_mounted),
      .img_size    (img_size),
      .img_readonly(img_readonly),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_ack      (sd_ack),
      .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr  (sd_buff_wr),
      .sd_buff_din (sd_buff_din),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_q       (mem_q),
      .mem_wr      (mem_wr),
      .mem_d       (mem_d),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Image memory (written only by the DUT) and the drive buffer.
   logic [7:0] img     [IMG_BYTES];
   logic [7:0] ref_img [IMG_BYTES];
   logic [7:0] dbuf    [512];
   int         mem_rd_cnt = 0;
   int         mem_wr_cnt = 0;

   initial begin
      for (int k = 0; k < IMG_BYTES; k++) img[k] = 8'(k) ^ 8'h5A;
      mem_q       = 8'h00;
      sd_buff_din = 8'h00;
      forever begin
         @(posedge clk);
         if (mem_rd) begin
            mem_q      <= img[mem_addr];
            mem_rd_cnt <= mem_rd_cnt + 1;
         end
         if (mem_wr) begin
            img[mem_addr] <= mem_d;
            mem_wr_cnt    <= mem_wr_cnt + 1;
         end
         sd_buff_din <= dbuf[sd_buff_addr];
      end
   end

   // Scoreboard: {addr, data} of every expected drive-buffer push.
   logic [16:0] exp_q [$];

   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && sd_buff_wr) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_push", 64'(sd_buff_wr), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("push_addr", 64'(sd_buff_addr), 64'(e[16:8]));
               check("push_data", 64'(sd_buff_dout), 64'(e[7:0]));
            end
         end
      end
   end

   // Reference model state.
   longint unsigned valid_sectors = 0;

   function automatic bit model_in_range(input longint unsigned lba);
      return (lba < valid_sectors) && (lba < longint'(CAP_SECT));
   endfunction

   task automatic wait_ack(input logic val, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sd_ack !== val && n < 3000);
   endtask

   task automatic mount(input logic [63:0] size);
      @(negedge clk);
      mount_req     = 1'b1;
      mount_size    = size;
      valid_sectors = size[63:9];
      @(negedge clk);
      check("mounted_pulse", 64'(img_mounted), 64'd1);
      mount_req = 1'b0;
      @(negedge clk);
      check("mounted_once", 64'(img_mounted), 64'd0);
      check("img_size", img_size, size);
   endtask

   task automatic cmp_img(input string name);
      int diffs = 0;
      for (int k = 0; k < IMG_BYTES; k++) if (img[k] !== ref_img[k]) diffs++;
      check(name, 64'(diffs), 64'd0);
   endtask

   task automatic push_read(input int lba);
      bit inr = model_in_range(longint'(lba));
      for (int i = 0; i < 512; i++)
         exp_q.push_back({9'(i), inr ? ref_img[lba * 512 + i] : 8'h00});
   endtask

   task automatic xfer(input int lba, input bit rd, input bit wr);
      bit inr = model_in_range(longint'(lba));
      int rd0, wr0, n;
      if (rd) push_read(lba);
      else if (inr && !WP) for (int i = 0; i < 512; i++) ref_img[lba * 512 + i] = dbuf[i];
      @(negedge clk);
      rd0    = mem_rd_cnt;
      wr0    = mem_wr_cnt;
      sd_lba = 32'(lba);
      sd_rd  = rd;
      sd_wr  = wr;
      wait_ack(1'b1, n);
      check("ack_delay", 64'(n), 64'(ACK_DELAY + 1));
      sd_rd  = 1'b0;
      sd_wr  = 1'b0;
      sd_lba = $urandom;  // must be ignored mid-transfer
      wait_ack(1'b0, n);
      check("ack_len", 64'(n), 64'd1024);
      @(negedge clk);
      check("idle_after_done", 64'(busy), 64'd0);
      check("mem_rd_count", 64'(mem_rd_cnt - rd0), (rd && inr) ? 64'd512 : 64'd0);
      check("mem_wr_count", 64'(mem_wr_cnt - wr0), (!rd && inr && !WP) ? 64'd512 : 64'd0);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      if (!rd) cmp_img("img_after_write");
   endtask

   initial begin
      int n;
      int lba;
      reset_n    = 1'b0;
      mount_req  = 1'b0;
      mount_size = 64'd0;
      sd_lba     = 32'd0;
      sd_rd      = 1'b0;
      sd_wr      = 1'b0;
      for (int k = 0; k < IMG_BYTES; k++) ref_img[k] = 8'(k) ^ 8'h5A;
      for (int i = 0; i < 512; i++) dbuf[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ack", 64'(sd_ack), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_buff_wr", 64'(sd_buff_wr), 64'd0);
      check("rst_mem_wr", 64'(mem_wr), 64'd0);
      check("rst_img_size", img_size, 64'd0);
      check("rst_mounted", 64'(img_mounted), 64'd0);
      check("img_readonly", 64'(img_readonly), 64'(WP));
      reset_n = 1'b1;

      mount(64'h0000_0000_0004_0000);

      // Directed cases.
      xfer(3, 1'b1, 1'b0);
      for (int i = 0; i < 512; i++) dbuf[i] = 8'(i) ^ 8'hFF;
      xfer(7, 1'b0, 1'b1);
      xfer(7, 1'b1, 1'b0);
      xfer(600, 1'b1, 1'b0);
      for (int i = 0; i < 512; i++) dbuf[i] = 8'($urandom);
      xfer(600, 1'b0, 1'b1);
      xfer(9, 1'b1, 1'b1);  // simultaneous: read wins
      xfer(511, 1'b1, 1'b0);
      xfer(512, 1'b1, 1'b0);

      // Write request held across DONE starts a second (write) transfer.
      for (int i = 0; i < 512; i++) dbuf[i] = 8'($urandom);
      push_read(12);
      @(negedge clk);
      n      = mem_wr_cnt;
      sd_lba = 32'd12;
      sd_rd  = 1'b1;
      sd_wr  = 1'b1;
      wait_ack(1'b1, lba);
      sd_rd = 1'b0;
      wait_ack(1'b0, lba);
      check("held_first_len", 64'(lba), 64'd1024);
      wait_ack(1'b1, lba);
      check("held_restart", 64'(sd_ack), 64'd1);
      sd_wr = 1'b0;
      if (!WP) for (int i = 0; i < 512; i++) ref_img[12 * 512 + i] = dbuf[i];
      wait_ack(1'b0, lba);
      @(negedge clk);
      check("held_mem_wr", 64'(mem_wr_cnt - n), WP ? 64'd0 : 64'd512);
      check("held_sb_drained", 64'(exp_q.size()), 64'd0);
      cmp_img("img_after_held");

      // Randomized transfers.
      for (int t = 0; t < 8; t++) begin
         case ($urandom_range(0, 3))
            0:       lba = $urandom_range(0, 15);
            1:       lba = $urandom_range(505, 520);
            2:       lba = $urandom_range(2040, 2100);
            default: lba = $urandom_range(0, 2047);
         endcase
         if ($urandom_range(0, 1) == 1) begin
            xfer(lba, 1'b1, 1'($urandom_range(0, 1)));
         end else begin
            for (int i = 0; i < 512; i++) dbuf[i] = 8'($urandom);
            xfer(lba, 1'b0, 1'b1);
         end
      end

      // Reset in the middle of a read.
      push_read(5);
      @(negedge clk);
      sd_lba = 32'd5;
      sd_rd  = 1'b1;
      wait_ack(1'b1, n);
      sd_rd = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(sd_buff_wr && sd_buff_addr == 9'd100) && n < 3000);
      check("reached_byte_100", 64'(sd_buff_addr), 64'd100);
      reset_n = 1'b0;
      #1;
      check("rst_mid_ack", 64'(sd_ack), 64'd0);
      check("rst_mid_buff_wr", 64'(sd_buff_wr), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check("rst_mid_img_size", img_size, 64'd0);
      mount(64'h0000_0000_0004_0000);
      xfer(1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
